lcm_stein: RTL and testbench
============================

LCM_STEIN -- requirements
Module: lcm_stein

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand width; the LCM result is 2*WIDTH bits.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 Port a, input, WIDTH bits: operand A, unsigned; captured on an accepted start.
REQ-006 Port b, input, WIDTH bits: operand B, unsigned; captured on an accepted start.
REQ-007 Port busy, output, 1 bit: high from the cycle after accept until the done cycle, inclusive.
REQ-008 Port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-009 Port gcd_out, output, WIDTH bits: gcd(a,b).
REQ-010 Port result, output, 2*WIDTH bits: lcm(a,b).

Function
REQ-011 FSM states SHALL be IDLE, ZERO, SHIFT, REDUCE, DIV, MUL, DONE.
REQ-012 IDLE with start=1: SHALL capture a/b into registers ra/rb and into working registers x/y, clear k, and go to ZERO if a==0 or b==0, else SHIFT.
REQ-013 start while busy=1 SHALL be ignored; operand changes while busy SHALL have no effect.
REQ-014 ZERO: gcd_out SHALL be set to a|b (gcd(0,n)=n, gcd(0,0)=0) and result to 0; go to DONE.
REQ-015 SHIFT: one step per cycle; while x and y are both even, shift both right by 1 and increment k; otherwise go to REDUCE.
REQ-016 REDUCE: one step per cycle, in priority order:
  - x even: x>>=1
  - else y even: y>>=1
  - else x>y: x=(x-y)>>1
  - else y>x: y=(y-x)>>1
  - else (x==y): g=x<<k, go to DIV
REQ-017 DIV: restoring division q=ra/g, one quotient bit per cycle, exactly WIDTH cycles; then go to MUL.
REQ-018 MUL: shift-add product q*rb into a 2*WIDTH accumulator, one multiplier bit per cycle, exactly WIDTH cycles; no overflow is possible and none SHALL be flagged.
REQ-019 DONE: done=1 for exactly one cycle; gcd_out=g and result=product are registered; return to IDLE.
REQ-020 gcd_out/result SHALL hold their values until the next DONE or reset and SHALL not change during a computation.
REQ-021 Latency from accept to done SHALL be at most 4*WIDTH+8 cycles (≤40 for WIDTH=8).
REQ-022 Zero-operand latency SHALL be exactly 2 cycles: accept -> ZERO -> DONE.
REQ-023 A new start SHALL be accepted in the IDLE cycle immediately after done.
REQ-024 All arithmetic SHALL be unsigned; the WIDTH-bit subtraction in REDUCE SHALL never underflow given the REQ-016 ordering.

Reset
REQ-025 While reset=1: state=IDLE, busy=0, done=0, gcd_out=0, result=0, and all working registers 0.
REQ-026 Reset asserted mid-computation SHALL abort it immediately (asynchronously); no done pulse SHALL follow.
REQ-027 After reset deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-028 Bench SHALL cover a=8, b=4 -> done with gcd_out=4, result=8; a=100, b=25 -> gcd_out=25, result=100; a=25, b=100 -> same values.
REQ-029 Bench SHALL cover a=67, b=9 -> gcd_out=1, result=603; a=255, b=254 -> gcd_out=1, result=64770, with latency ≤40 cycles.
REQ-030 Bench SHALL cover a=0, b=3 -> gcd_out=3, result=0, done exactly 2 cycles after accept; a=0, b=0 -> gcd_out=0, result=0.
REQ-031 Bench SHALL cover a=120, b=10, then start pulsed high with a=7 during busy -> completes with gcd_out=10, result=120; the extra start is ignored.
REQ-032 Bench SHALL cover reset pulsed 10 cycles into a=255, b=254 -> all outputs 0, no done; then a=3, b=3 -> gcd_out=3, result=3.
REQ-033 Bench SHALL cover back-to-back runs, with start held high across done -> the second computation starts on the IDLE cycle and both results are correct.

Source files
------------

// File: rtl/lcm_stein.sv
// lcm_stein: sequential GCD/LCM engine.
// The GCD comes from Stein's binary algorithm. The LCM is then formed as
// (a / gcd) * b, using a restoring divider followed by a shift-add multiplier.
// Both results are registered together when the engine reaches its DONE state.
module lcm_stein #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   gcd_out,
  output logic [2*WIDTH-1:0] result
);

  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    SHIFT,
    REDUCE,
    DIV,
    MUL,
    DONE
  } state_t;

  state_t state, state_next;

  // Captured operands, kept for the divide and multiply phases.
  logic [WIDTH-1:0]   ra, rb;
  // Stein working pair and the shared power of two removed from both.
  logic [WIDTH-1:0]   x, y;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   g;
  // In DIV, dq holds the dividend and receives quotient bits. In MUL it is
  // the multiplier and shifts right.
  logic [WIDTH-1:0]   dq;
  logic [WIDTH-1:0]   rem;
  logic [KW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand;

  // Step values for the divider and multiplier.
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   sub;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   dq_next;
  logic [2*WIDTH-1:0] acc_next;
  logic               last;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // One restoring-division step and one shift-add step, computed from the current registers.
  always_comb begin
    trial = {rem, dq[WIDTH-1]};
    fits  = (trial >= {1'b0, g});
    // When the trial fits, trial - g < g, so the low WIDTH bits hold the exact difference.
    sub      = trial[WIDTH-1:0] - g;
    rem_next = fits ? sub : trial[WIDTH-1:0];
    dq_next  = {dq[WIDTH-2:0], fits};
    acc_next = dq[0] ? (acc + mcand) : acc;
    last     = (cnt == KW'(WIDTH - 1));
  end

  // State register; reset aborts any computation immediately.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, whatever the order of the statements.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ((a == '0) || (b == '0)) ? ZERO : SHIFT;
      ZERO:    state_next = DONE;
      SHIFT:   if (x[0] || y[0]) state_next = REDUCE;
      REDUCE:  if (x[0] && y[0] && (x == y)) state_next = DIV;
      DIV:     if (last) state_next = MUL;
      MUL:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, Stein steps, divide, multiply and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra      <= '0;
      rb      <= '0;
      x       <= '0;
      y       <= '0;
      k       <= '0;
      g       <= '0;
      dq      <= '0;
      rem     <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      gcd_out <= '0;
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra <= a;
            rb <= b;
            x  <= a;
            y  <= b;
            k  <= '0;
          end
        end
        ZERO: begin
          // gcd(0,n) = n and gcd(0,0) = 0; the LCM with a zero operand is 0.
          gcd_out <= ra | rb;
          result  <= '0;
        end
        SHIFT: begin
          if (!x[0] && !y[0]) begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + KW'(1);
          end
        end
        REDUCE: begin
          // This ordering guarantees the subtracted value is never the larger one.
          if (!x[0])      x <= x >> 1;
          else if (!y[0]) y <= y >> 1;
          else if (x > y) x <= (x - y) >> 1;
          else if (y > x) y <= (y - x) >> 1;
          else begin
            g   <= x << k;
            dq  <= ra;
            rem <= '0;
            cnt <= '0;
          end
        end
        DIV: begin
          rem <= rem_next;
          dq  <= dq_next;
          cnt <= cnt + KW'(1);
          if (last) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, rb};
          end
        end
        MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          dq    <= dq >> 1;
          cnt   <= cnt + KW'(1);
          if (last) begin
            gcd_out <= g;
            result  <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_stein.sv
// Directed testbench for lcm_stein (WIDTH = 8). Expected values are worked out by hand.
module tb_lcm_stein;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done;
  logic [7:0]  gcd_out;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  lcm_stein #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .gcd_out(gcd_out),
    .result (result)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge, then wait (bounded) for done.
  // Latency is the number of rising edges from the accept edge up to done.
  task automatic do_op(input logic [7:0] aa, input logic [7:0] bb,
                       output int lat, output logic [7:0] g,
                       output logic [15:0] r, output logic ok);
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; ok = 1'b0; g = 'x; r = 'x;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        ok = 1'b1; g = gcd_out; r = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (gcd_out !== 8'd0 || result !== 16'd0) begin
      errors++; $display("FAIL reset_outputs gcd=%0d result=%0d expected 0 0", gcd_out, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0]  ta [5] = '{8'd8, 8'd100, 8'd25, 8'd67, 8'd255};
    logic [7:0]  tb_[5] = '{8'd4, 8'd25, 8'd100, 8'd9, 8'd254};
    logic [7:0]  eg [5] = '{8'd4, 8'd25, 8'd25, 8'd1, 8'd1};
    logic [15:0] el [5] = '{16'd8, 16'd100, 16'd100, 16'd603, 16'd64770};
    int lat; logic [7:0] g; logic [15:0] r; logic ok;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb_[i], lat, g, r, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL basic_timeout a=%0d b=%0d no done within bound", ta[i], tb_[i]);
      end
      checks++;
      if (g !== eg[i]) begin
        errors++; $display("FAIL basic_gcd a=%0d b=%0d got %0d expected %0d", ta[i], tb_[i], g, eg[i]);
      end
      checks++;
      if (r !== el[i]) begin
        errors++; $display("FAIL basic_lcm a=%0d b=%0d got %0d expected %0d", ta[i], tb_[i], r, el[i]);
      end
      checks++;
      if (lat > 40) begin
        errors++; $display("FAIL basic_latency a=%0d b=%0d got %0d expected <=40", ta[i], tb_[i], lat);
      end
      // The results must hold after done has dropped.
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || gcd_out !== eg[i] || result !== el[i]) begin
        errors++;
        $display("FAIL basic_hold done=%b gcd=%0d result=%0d expected 0 %0d %0d", done, gcd_out, result, eg[i], el[i]);
      end
    end
  endtask

  task automatic test_zero();
    int lat; logic [7:0] g; logic [15:0] r; logic ok;
    do_op(8'd0, 8'd3, lat, g, r, ok);
    checks++;
    if (!ok || lat !== 2) begin
      errors++; $display("FAIL zero_latency ok=%b got %0d expected 2", ok, lat);
    end
    checks++;
    if (g !== 8'd3 || r !== 16'd0) begin
      errors++; $display("FAIL zero_0_3 gcd=%0d result=%0d expected 3 0", g, r);
    end
    do_op(8'd0, 8'd0, lat, g, r, ok);
    checks++;
    if (!ok || lat !== 2 || g !== 8'd0 || r !== 16'd0) begin
      errors++; $display("FAIL zero_0_0 ok=%b lat=%0d gcd=%0d result=%0d expected 1 2 0 0", ok, lat, g, r);
    end
    do_op(8'd5, 8'd0, lat, g, r, ok);
    checks++;
    if (!ok || lat !== 2 || g !== 8'd5 || r !== 16'd0) begin
      errors++; $display("FAIL zero_5_0 ok=%b lat=%0d gcd=%0d result=%0d expected 1 2 5 0", ok, lat, g, r);
    end
  endtask

  task automatic test_busy_start();
    logic seen;
    // The outputs still hold the previous run's results (5, 0).
    @(negedge clk);
    a = 8'd120; b = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_accept got %b expected 1", busy);
    end
    repeat (3) @(negedge clk);
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (gcd_out !== 8'd5 || result !== 16'd0) begin
      errors++; $display("FAIL busy_outputs_stable gcd=%0d result=%0d expected 5 0", gcd_out, result);
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || gcd_out !== 8'd10 || result !== 16'd120) begin
      errors++; $display("FAIL busy_ignore_start done=%b gcd=%0d result=%0d expected 1 10 120", seen, gcd_out, result);
    end
    // No second run may have been queued by the ignored start.
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL busy_no_rerun busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] g; logic [15:0] r; logic ok; logic seen;
    @(negedge clk);
    a = 8'd255; b = 8'd254; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || gcd_out !== 8'd0 || result !== 16'd0) begin
      errors++;
      $display("FAIL abort_async busy=%b done=%b gcd=%0d result=%0d expected 0 0 0 0", busy, done, gcd_out, result);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_no_done activity seen after reset, expected none");
    end
    do_op(8'd3, 8'd3, lat, g, r, ok);
    checks++;
    if (!ok || g !== 8'd3 || r !== 16'd3) begin
      errors++; $display("FAIL abort_then_3_3 ok=%b gcd=%0d result=%0d expected 1 3 3", ok, g, r);
    end
  endtask

  task automatic test_back_to_back();
    logic seen;
    @(negedge clk);
    a = 8'd12; b = 8'd18; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || gcd_out !== 8'd6 || result !== 16'd36) begin
      errors++; $display("FAIL b2b_first done=%b gcd=%0d result=%0d expected 1 6 36", seen, gcd_out, result);
    end
    a = 8'd14; b = 8'd21;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_cycle busy=%b expected 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept busy=%b expected 1", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || gcd_out !== 8'd7 || result !== 16'd42) begin
      errors++; $display("FAIL b2b_second done=%b gcd=%0d result=%0d expected 1 7 42", seen, gcd_out, result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_busy_start();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
